issue_unit_nw: RTL and testbench

- Parametrised in-order N-wide issue stage with an integrated shift-register scoreboard.
- Reads up to ISSUE_WIDTH heads from the issue queue and checks operand readiness from regfile, bypass or scoreboard.
- Resolves intra-bundle RAW hazards and branch/delay-slot pairing, then issues the longest legal prefix into registered FU-request outputs.
- Sits between the issue queue and the execute lanes.

---
 rtl/issue_unit_nw_if.sv | 52 +++++
 rtl/issue_unit_nw.sv | 180 ++++++++++++++++++
 tb/tb_issue_unit_nw.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/issue_unit_nw_if.sv
// Issue-stage bus: queue heads, regfile/bypass operand ports, scoreboard taps and FU requests.
// The issue unit takes the slave side; the queue/regfile/execute environment takes the master side.
interface issue_unit_nw_if #(
  parameter int ISSUE_WIDTH = 2,
  parameter int DATA_W      = 32,
  parameter int STAGES      = 3,
  parameter int PAYLOAD_W   = 64
);
  localparam int NOPS   = 2 * ISSUE_WIDTH;
  localparam int CNT_W  = $clog2(ISSUE_WIDTH + 1);
  localparam int LANE_W = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

  logic                                  flash;
  logic                                  stall;
  logic [CNT_W-1:0]                      iq_size;
  logic [CNT_W-1:0]                      iq_pop_number;
  logic [NOPS-1:0][4:0]                  slot_src_addr;
  logic [NOPS-1:0]                       slot_src_need;
  logic [NOPS-1:0][DATA_W-1:0]           slot_imm;
  logic [ISSUE_WIDTH-1:0]                slot_dst_need;
  logic [ISSUE_WIDTH-1:0][4:0]           slot_dst_addr;
  logic [ISSUE_WIDTH-1:0]                slot_is_branch;
  logic [ISSUE_WIDTH-1:0][STAGES-1:0]    slot_accept_mask;
  logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0] slot_payload;
  logic [NOPS-1:0][4:0]                  regfile_read_addr;
  logic [NOPS-1:0][DATA_W-1:0]           regfile_read_data;
  logic [NOPS-1:0][STAGES-1:0]           sb_position;
  logic [NOPS-1:0][LANE_W-1:0]           sb_lane;
  logic [NOPS-1:0][DATA_W-1:0]           bypass_data;
  logic [ISSUE_WIDTH-1:0]                fu_valid;
  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]    fu_num1;
  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]    fu_num2;
  logic [ISSUE_WIDTH-1:0]                fu_dst_need;
  logic [ISSUE_WIDTH-1:0][4:0]           fu_dst_addr;
  logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0] fu_payload;

  modport slave (
    input  flash, stall, iq_size, slot_src_addr, slot_src_need, slot_imm,
           slot_dst_need, slot_dst_addr, slot_is_branch, slot_accept_mask,
           slot_payload, regfile_read_data, bypass_data,
    output iq_pop_number, regfile_read_addr, sb_position, sb_lane,
           fu_valid, fu_num1, fu_num2, fu_dst_need, fu_dst_addr, fu_payload
  );

  modport master (
    output flash, stall, iq_size, slot_src_addr, slot_src_need, slot_imm,
           slot_dst_need, slot_dst_addr, slot_is_branch, slot_accept_mask,
           slot_payload, regfile_read_data, bypass_data,
    input  iq_pop_number, regfile_read_addr, sb_position, sb_lane,
           fu_valid, fu_num1, fu_num2, fu_dst_need, fu_dst_addr, fu_payload
  );
endinterface

// File: rtl/issue_unit_nw.sv
// In-order N-wide issue stage with a per-register shift-register scoreboard.
// Issues the longest ready prefix of the queue head into registered FU requests.

module issue_unit_nw_opnd #(
  parameter int DATA_W = 32,
  parameter int STAGES = 3
) (
  input  logic              need_i,
  input  logic              hazard_i,
  input  logic [STAGES-1:0] pos_i,
  input  logic [STAGES-1:0] acc_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] rf_i,
  input  logic [DATA_W-1:0] byp_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] value_o
);
  always_comb begin
    ready_o = 1'b0;
    value_o = '0;
    if (!need_i) begin
      ready_o = 1'b1;
      value_o = imm_i;
    end else if (!hazard_i) begin
      // Retired producers come from the regfile; in-flight ones only from accepted stages.
      if (pos_i == '0) begin
        ready_o = 1'b1;
        value_o = rf_i;
      end else if ((pos_i & acc_i) != '0) begin
        ready_o = 1'b1;
        value_o = byp_i;
      end
    end
  end
endmodule

module issue_unit_nw #(
  parameter int ISSUE_WIDTH = 2,
  parameter int DATA_W      = 32,
  parameter int STAGES      = 3,
  parameter int PAYLOAD_W   = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  issue_unit_nw_if.slave bus
);
  localparam int NOPS   = 2 * ISSUE_WIDTH;
  localparam int CNT_W  = $clog2(ISSUE_WIDTH + 1);
  localparam int LANE_W = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
  localparam logic [STAGES-1:0] NEWEST = STAGES'(1) << (STAGES - 1);

  typedef struct packed {
    logic [STAGES-1:0] pos;
    logic [STAGES-1:0] acc;
    logic [LANE_W-1:0] lane;
  } sb_entry_t;

  typedef struct packed {
    logic                 vld;
    logic [DATA_W-1:0]    num1;
    logic [DATA_W-1:0]    num2;
    logic                 dst_need;
    logic [4:0]           dst_addr;
    logic [PAYLOAD_W-1:0] payload;
  } fu_req_t;

  sb_entry_t                         sb_q [32];
  sb_entry_t                         sb_d [32];
  fu_req_t   [ISSUE_WIDTH-1:0]       fu_q, fu_d;

  logic [NOPS-1:0]                   op_rdy;
  logic [NOPS-1:0][DATA_W-1:0]       op_val;
  logic [ISSUE_WIDTH-1:0]            slot_rdy;
  logic [ISSUE_WIDTH-1:0]            issue;
  logic [CNT_W-1:0]                  pfx;
  logic [CNT_W-1:0]                  k;
  logic                              run;
  logic                              brk;

  assign bus.regfile_read_addr = bus.slot_src_addr;

  for (genvar o = 0; o < NOPS; o++) begin : g_op
    localparam int SLOT = o / 2;
    logic [4:0] addr;
    logic       haz;
    sb_entry_t  ent;

    assign addr = bus.slot_src_addr[o];
    assign ent  = (addr == 5'd0) ? '0 : sb_q[addr];
    assign bus.sb_position[o] = ent.pos;
    assign bus.sb_lane[o]     = ent.lane;

    // No forwarding inside a bundle: an earlier slot writing this source blocks it.
    always_comb begin
      haz = 1'b0;
      for (int j = 0; j < SLOT; j++)
        if (bus.slot_dst_need[j] && (bus.slot_dst_addr[j] != 5'd0) &&
            (bus.slot_dst_addr[j] == addr))
          haz = 1'b1;
    end

    issue_unit_nw_opnd #(.DATA_W(DATA_W), .STAGES(STAGES)) u_opnd (
      .need_i   (bus.slot_src_need[o]),
      .hazard_i (haz),
      .pos_i    (ent.pos),
      .acc_i    (ent.acc),
      .imm_i    (bus.slot_imm[o]),
      .rf_i     (bus.regfile_read_data[o]),
      .byp_i    (bus.bypass_data[o]),
      .ready_o  (op_rdy[o]),
      .value_o  (op_val[o])
    );
  end

  always_comb begin
    pfx = '0;
    run = 1'b1;
    brk = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      slot_rdy[i] = (CNT_W'(i) < bus.iq_size) && op_rdy[2*i] && op_rdy[2*i+1];
      if (run && slot_rdy[i]) pfx = pfx + CNT_W'(1);
      else                    run = 1'b0;
    end
    // A branch must leave together with its delay slot, so it cannot close the bundle.
    for (int i = 0; i < ISSUE_WIDTH; i++)
      if ((pfx == CNT_W'(i + 1)) && bus.slot_is_branch[i]) brk = 1'b1;
    k = (!rst_n || bus.flash || bus.stall) ? '0 : pfx - CNT_W'(brk);
    for (int i = 0; i < ISSUE_WIDTH; i++)
      issue[i] = CNT_W'(i) < k;
  end

  assign bus.iq_pop_number = k;

  always_comb begin
    fu_d = fu_q;
    sb_d = sb_q;
    if (bus.flash) begin
      fu_d = '0;
      for (int r = 0; r < 32; r++) sb_d[r].pos = '0;
    end else if (!bus.stall) begin
      for (int r = 0; r < 32; r++) sb_d[r].pos = sb_q[r].pos >> 1;
      // Ascending slot order lets the higher slot win a shared destination.
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        fu_d[i] = '0;
        if (issue[i]) begin
          fu_d[i].vld      = 1'b1;
          fu_d[i].num1     = op_val[2*i];
          fu_d[i].num2     = op_val[2*i+1];
          fu_d[i].dst_need = bus.slot_dst_need[i];
          fu_d[i].dst_addr = bus.slot_dst_addr[i];
          fu_d[i].payload  = bus.slot_payload[i];
          if (bus.slot_dst_need[i] && (bus.slot_dst_addr[i] != 5'd0)) begin
            sb_d[bus.slot_dst_addr[i]].pos  = NEWEST;
            sb_d[bus.slot_dst_addr[i]].acc  = bus.slot_accept_mask[i];
            sb_d[bus.slot_dst_addr[i]].lane = LANE_W'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fu_q <= '0;
      for (int r = 0; r < 32; r++) sb_q[r] <= '0;
    end else begin
      fu_q <= fu_d;
      sb_q <= sb_d;
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_fu
    assign bus.fu_valid[i]    = fu_q[i].vld;
    assign bus.fu_num1[i]     = fu_q[i].num1;
    assign bus.fu_num2[i]     = fu_q[i].num2;
    assign bus.fu_dst_need[i] = fu_q[i].dst_need;
    assign bus.fu_dst_addr[i] = fu_q[i].dst_addr;
    assign bus.fu_payload[i]  = fu_q[i].payload;
  end
endmodule

// File: tb/tb_issue_unit_nw.sv
// Directed bench for issue_unit_nw: a 2-wide instance driven from a vector table
// plus short hand-written sequences (4-wide issue, mid-run reset).
module tb_issue_unit_nw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  issue_unit_nw_if #(.ISSUE_WIDTH(2), .DATA_W(32), .STAGES(3), .PAYLOAD_W(64)) bus ();
  issue_unit_nw_if #(.ISSUE_WIDTH(4), .DATA_W(32), .STAGES(3), .PAYLOAD_W(64)) bus4 ();

  issue_unit_nw #(.ISSUE_WIDTH(2), .DATA_W(32), .STAGES(3), .PAYLOAD_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  issue_unit_nw #(.ISSUE_WIDTH(4), .DATA_W(32), .STAGES(3), .PAYLOAD_W(64)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  function automatic logic [31:0] rf(input logic [4:0] a);
    if (a == 5'd2) return 32'd5;
    if (a == 5'd3) return 32'd7;
    return 32'd100 + {27'd0, a};
  endfunction

  always_comb for (int o = 0; o < 4; o++) bus.regfile_read_data[o]  = rf(bus.regfile_read_addr[o]);
  always_comb for (int o = 0; o < 8; o++) bus4.regfile_read_data[o] = rf(bus4.regfile_read_addr[o]);

  typedef struct {
    logic [1:0] sz;
    logic [4:0] a0, a1, a2, a3;
    logic [3:0] nd;
    logic [4:0] d0, d1;
    logic [1:0] dn, br;
    logic [2:0] ac0, ac1;
    logic       st, fl;
    logic [1:0] pop;
    logic [2:0] p0, p2;
    logic [1:0] vld;
    logic [31:0] n10, n20, n11, n21;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int v);
    bus.iq_size = t.sz;
    bus.slot_src_addr[0] = t.a0;
    bus.slot_src_addr[1] = t.a1;
    bus.slot_src_addr[2] = t.a2;
    bus.slot_src_addr[3] = t.a3;
    bus.slot_src_need = t.nd;
    bus.slot_dst_addr[0] = t.d0;
    bus.slot_dst_addr[1] = t.d1;
    bus.slot_dst_need = t.dn;
    bus.slot_is_branch = t.br;
    bus.slot_accept_mask[0] = t.ac0;
    bus.slot_accept_mask[1] = t.ac1;
    bus.stall = t.st;
    bus.flash = t.fl;
    for (int i = 0; i < 2; i++) bus.slot_payload[i] = {32'(v), 32'(i + 1)};
  endtask

  initial begin
    // sz a0 a1 a2 a3 nd d0 d1 dn br ac0 ac1 st fl | pop p0 p2 vld n10 n20 n11 n21
    vt[0]  = '{2, 2, 3, 5, 6, 4'b1111, 1, 4, 2'b11, 2'b00, 3'b100, 3'b100, 0, 0, 2, 3'b000, 3'b000, 2'b11, 5, 7, 105, 106};
    vt[1]  = '{2, 1, 0, 8, 0, 4'b0101, 8, 9, 2'b11, 2'b00, 3'b001, 3'b100, 0, 0, 1, 3'b100, 3'b000, 2'b01, 1000, 2001, 0, 0};
    vt[2]  = '{2, 8, 0, 11, 0, 4'b0101, 9, 10, 2'b11, 2'b00, 3'b100, 3'b100, 0, 0, 0, 3'b100, 3'b000, 2'b00, 0, 0, 0, 0};
    vt[3]  = '{2, 8, 0, 11, 0, 4'b0101, 9, 10, 2'b11, 2'b00, 3'b100, 3'b100, 0, 0, 0, 3'b010, 3'b000, 2'b00, 0, 0, 0, 0};
    vt[4]  = '{2, 8, 0, 11, 0, 4'b0101, 9, 10, 2'b11, 2'b00, 3'b100, 3'b100, 0, 0, 2, 3'b001, 3'b000, 2'b11, 1000, 2001, 111, 2003};
    vt[5]  = '{2, 2, 0, 3, 0, 4'b0101, 12, 0, 2'b01, 2'b10, 3'b100, 3'b000, 0, 0, 1, 3'b000, 3'b000, 2'b01, 5, 2001, 0, 0};
    vt[6]  = '{2, 3, 0, 9, 0, 4'b0101, 0, 13, 2'b10, 2'b01, 3'b000, 3'b100, 0, 0, 0, 3'b000, 3'b010, 2'b00, 0, 0, 0, 0};
    vt[7]  = '{2, 3, 0, 9, 0, 4'b0101, 0, 13, 2'b10, 2'b01, 3'b000, 3'b100, 0, 0, 0, 3'b000, 3'b001, 2'b00, 0, 0, 0, 0};
    vt[8]  = '{2, 3, 0, 9, 0, 4'b0101, 0, 13, 2'b10, 2'b01, 3'b000, 3'b100, 0, 0, 2, 3'b000, 3'b000, 2'b11, 7, 2001, 109, 2003};
    vt[9]  = '{2, 13, 0, 0, 0, 4'b0001, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 0, 3'b100, 3'b000, 2'b11, 7, 2001, 109, 2003};
    vt[10] = '{2, 13, 0, 0, 0, 4'b0001, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 0, 3'b100, 3'b000, 2'b11, 7, 2001, 109, 2003};
    vt[11] = '{2, 13, 0, 0, 0, 4'b0001, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 0, 3'b100, 3'b000, 2'b11, 7, 2001, 109, 2003};
    vt[12] = '{0, 13, 0, 0, 0, 4'b0001, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 3'b100, 3'b000, 2'b00, 0, 0, 0, 0};
    vt[13] = '{0, 13, 0, 0, 0, 4'b0001, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 3'b010, 3'b000, 2'b00, 0, 0, 0, 0};
    vt[14] = '{1, 2, 3, 0, 0, 4'b0011, 7, 0, 2'b01, 2'b00, 3'b100, 3'b000, 0, 0, 1, 3'b000, 3'b000, 2'b01, 5, 7, 0, 0};
    vt[15] = '{1, 7, 0, 0, 0, 4'b0001, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 1, 3'b100, 3'b000, 2'b01, 1000, 2001, 0, 0};
    vt[16] = '{2, 7, 0, 0, 0, 4'b0001, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 1, 1, 0, 3'b010, 3'b000, 2'b00, 0, 0, 0, 0};
    vt[17] = '{0, 7, 0, 0, 0, 4'b0001, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0, 0};

    for (int o = 0; o < 4; o++) begin
      bus.slot_imm[o]    = 32'd2000 + 32'(o);
      bus.bypass_data[o] = 32'd1000 + 32'(o);
    end
    for (int o = 0; o < 8; o++) begin
      bus4.slot_imm[o]    = 32'd3000 + 32'(o);
      bus4.bypass_data[o] = 32'd4000 + 32'(o);
    end
    bus4.iq_size = '0; bus4.slot_src_addr = '0; bus4.slot_src_need = '0;
    bus4.slot_dst_addr = '0; bus4.slot_dst_need = '0; bus4.slot_is_branch = '0;
    bus4.slot_accept_mask = '0; bus4.slot_payload = '0; bus4.stall = 1'b0; bus4.flash = 1'b0;

    // Reset: all-immediate slots would be ready, yet nothing pops while rst_n is low.
    apply('{2, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 99);
    #1;
    chk("reset_pop", 64'(bus.iq_pop_number), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fu_valid", 64'(bus.fu_valid), 64'd0);
    chk("reset_fu_num1_0", 64'(bus.fu_num1[0]), 64'd0);
    chk("reset_fu_payload_0", bus.fu_payload[0], 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 18; v++) begin
      apply(vt[v], v);
      #1;
      chk($sformatf("v%0d_pop", v), 64'(bus.iq_pop_number), 64'(vt[v].pop));
      chk($sformatf("v%0d_sbpos0", v), 64'(bus.sb_position[0]), 64'(vt[v].p0));
      chk($sformatf("v%0d_sbpos2", v), 64'(bus.sb_position[2]), 64'(vt[v].p2));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_fu_valid", v), 64'(bus.fu_valid), 64'(vt[v].vld));
      chk($sformatf("v%0d_num1_0", v), 64'(bus.fu_num1[0]), 64'(vt[v].n10));
      chk($sformatf("v%0d_num2_0", v), 64'(bus.fu_num2[0]), 64'(vt[v].n20));
      chk($sformatf("v%0d_num1_1", v), 64'(bus.fu_num1[1]), 64'(vt[v].n11));
      chk($sformatf("v%0d_num2_1", v), 64'(bus.fu_num2[1]), 64'(vt[v].n21));
      if (!vt[v].st && !vt[v].fl) begin
        chk($sformatf("v%0d_dst_addr_0", v), 64'(bus.fu_dst_addr[0]), vt[v].vld[0] ? 64'(vt[v].d0) : 64'd0);
        chk($sformatf("v%0d_dst_need_0", v), 64'(bus.fu_dst_need[0]), vt[v].vld[0] ? 64'(vt[v].dn[0]) : 64'd0);
        chk($sformatf("v%0d_payload_0", v), bus.fu_payload[0], vt[v].vld[0] ? {32'(v), 32'd1} : 64'd0);
      end
    end

    // 4-wide: four independent ops all leave; then a branch in the top slot is held back.
    bus4.iq_size = 3'd4;
    for (int i = 0; i < 4; i++) begin
      bus4.slot_src_addr[2*i]   = 5'(i + 2);
      bus4.slot_src_addr[2*i+1] = 5'd0;
      bus4.slot_dst_addr[i]     = 5'(20 + i);
      bus4.slot_accept_mask[i]  = 3'b100;
      bus4.slot_payload[i]      = 64'(i + 1);
    end
    bus4.slot_src_need = 8'b0101_0101;
    bus4.slot_dst_need = 4'hF;
    #1;
    chk("w4_pop4", 64'(bus4.iq_pop_number), 64'd4);
    @(posedge clk);
    #1;
    chk("w4_fu_valid", 64'(bus4.fu_valid), 64'hF);
    chk("w4_num1_0", 64'(bus4.fu_num1[0]), 64'd5);
    chk("w4_num1_3", 64'(bus4.fu_num1[3]), 64'd105);
    chk("w4_num2_3", 64'(bus4.fu_num2[3]), 64'd3007);
    bus4.slot_src_addr[0] = 5'd23;
    bus4.slot_dst_need    = 4'h0;
    bus4.slot_is_branch   = 4'b1000;
    #1;
    chk("w4_sbpos_r23", 64'(bus4.sb_position[0]), 64'b100);
    chk("w4_sblane_r23", 64'(bus4.sb_lane[0]), 64'd3);
    chk("w4_branch_top_pop", 64'(bus4.iq_pop_number), 64'd3);
    @(posedge clk);
    #1;
    chk("w4_branch_fu_valid", 64'(bus4.fu_valid), 64'b0111);
    chk("w4_bypass_num1_0", 64'(bus4.fu_num1[0]), 64'd4000);
    bus4.iq_size = '0;

    // Mid-run reset drops the issued request and the in-flight scoreboard entry.
    apply('{1, 2, 3, 0, 0, 4'b0011, 20, 0, 2'b01, 2'b00, 3'b100, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 50);
    @(posedge clk);
    #1;
    chk("mr_fu_valid_before", 64'(bus.fu_valid), 64'b01);
    apply('{1, 20, 0, 0, 0, 4'b0001, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 51);
    rst_n = 1'b0;
    #1;
    chk("mr_pop_in_reset", 64'(bus.iq_pop_number), 64'd0);
    @(posedge clk);
    #1;
    chk("mr_fu_valid", 64'(bus.fu_valid), 64'd0);
    chk("mr_fu_num1_0", 64'(bus.fu_num1[0]), 64'd0);
    chk("mr_sbpos_r20", 64'(bus.sb_position[0]), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("mr_pop_after", 64'(bus.iq_pop_number), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
